// File: rtl/alu_accum_seq.sv
// WIDTH-bit accumulator ALU with a valid/ready operand port, an iterative shift-add
// multiplier, and wrap or saturate overflow handling under an OFF/READY/RUN/ERROR FSM.
module alu_accum_seq #(
  parameter int unsigned WIDTH = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             err_clr,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned ProdW = 2 * WIDTH;

  typedef enum logic [1:0] {
    sOff   = 2'b00,
    sReady = 2'b01,
    sRun   = 2'b10,
    sError = 2'b11
  } stateT;

  typedef enum logic [2:0] {
    opAnd  = 3'd0,
    opOr   = 3'd1,
    opXor  = 3'd2,
    opNot  = 3'd3,
    opAdd  = 3'd4,
    opSub  = 3'd5,
    opMul  = 3'd6,
    opLoad = 3'd7
  } opT;

  stateT             stateQ, stateNext;
  logic [WIDTH-1:0]  accQ, accNext;
  logic [WIDTH-1:0]  mulBQ, mulBNext;
  logic [ProdW-1:0]  mcandQ, mcandNext;
  logic [ProdW-1:0]  prodQ, prodNext;
  logic [CntW-1:0]   cntQ, cntNext;
  logic              resultValidQ, resultValidNext;
  logic              overflowQ, overflowNext;
  logic              inReadyQ, inReadyNext;

  logic [WIDTH:0]    sumW, diffW;
  logic [WIDTH-1:0]  aluRes;
  logic              aluOvf;
  logic [ProdW-1:0]  prodSum;
  logic              mulOvf;
  logic [WIDTH-1:0]  mulRes;

  // Single-cycle ops against the current accumulator
  always_comb begin
    sumW   = {1'b0, accQ} + {1'b0, operand};
    diffW  = {1'b0, accQ} - {1'b0, operand};
    aluRes = accQ;
    aluOvf = 1'b0;
    case (opT'(op))
      opAnd:  aluRes = accQ & operand;
      opOr:   aluRes = accQ | operand;
      opXor:  aluRes = accQ ^ operand;
      opNot:  aluRes = ~accQ;
      opAdd: begin
        aluOvf = sumW[WIDTH];
        aluRes = (aluOvf && SAT) ? '1 : sumW[WIDTH-1:0];
      end
      opSub: begin
        aluOvf = diffW[WIDTH];
        aluRes = (aluOvf && SAT) ? '0 : diffW[WIDTH-1:0];
      end
      opLoad: aluRes = operand;
      default: aluRes = accQ;
    endcase
  end

  // One partial product per RUN cycle; multiplier bit consumed LSB first
  always_comb begin
    prodSum = prodQ + (mulBQ[0] ? mcandQ : '0);
    mulOvf  = |prodSum[ProdW-1:WIDTH];
    mulRes  = (mulOvf && SAT) ? '1 : prodSum[WIDTH-1:0];
  end

  // Next-state and datapath control
  always_comb begin
    stateNext       = stateQ;
    accNext         = accQ;
    mulBNext        = mulBQ;
    mcandNext       = mcandQ;
    prodNext        = prodQ;
    cntNext         = cntQ;
    resultValidNext = 1'b0;
    overflowNext    = overflowQ;

    if (!on) begin
      // Dropping enable wins over accepts, err_clr and in-flight multiplies
      stateNext    = sOff;
      accNext      = '0;
      cntNext      = '0;
      prodNext     = '0;
      overflowNext = 1'b0;
    end else begin
      case (stateQ)
        sOff: stateNext = sReady;
        sReady: begin
          if (in_valid) begin
            if (opT'(op) == opMul) begin
              mulBNext  = operand;
              mcandNext = ProdW'(accQ);
              prodNext  = '0;
              cntNext   = '0;
              stateNext = sRun;
            end else begin
              accNext         = aluRes;
              resultValidNext = 1'b1;
              if (aluOvf) begin
                overflowNext = 1'b1;
                stateNext    = sError;
              end
            end
          end
        end
        sRun: begin
          prodNext  = prodSum;
          mcandNext = mcandQ << 1;
          mulBNext  = mulBQ >> 1;
          cntNext   = cntQ + CntW'(1);
          if (cntQ == CntW'(WIDTH - 1)) begin
            accNext         = mulRes;
            resultValidNext = 1'b1;
            cntNext         = '0;
            if (mulOvf) begin
              overflowNext = 1'b1;
              stateNext    = sError;
            end else begin
              stateNext = sReady;
            end
          end
        end
        sError: begin
          if (err_clr) begin
            overflowNext = 1'b0;
            stateNext    = sReady;
          end
        end
        default: stateNext = sOff;
      endcase
    end

    inReadyNext = (stateNext == sReady);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ       <= sOff;
      accQ         <= '0;
      mulBQ        <= '0;
      mcandQ       <= '0;
      prodQ        <= '0;
      cntQ         <= '0;
      resultValidQ <= 1'b0;
      overflowQ    <= 1'b0;
      inReadyQ     <= 1'b0;
    end else begin
      stateQ       <= stateNext;
      accQ         <= accNext;
      mulBQ        <= mulBNext;
      mcandQ       <= mcandNext;
      prodQ        <= prodNext;
      cntQ         <= cntNext;
      resultValidQ <= resultValidNext;
      overflowQ    <= overflowNext;
      inReadyQ     <= inReadyNext;
    end
  end

  assign in_ready     = inReadyQ;
  assign result       = accQ;
  assign result_valid = resultValidQ;
  assign overflow     = overflowQ;
  assign state        = stateQ;

endmodule
